// File: rtl/pipeline_pkg.sv
// Shared pipeline types: forwarding selects, MDU occupancy states and the
// helper that decides whether a later stage's destination matches a source.
package pipeline_pkg;

    localparam int MDU_CNT_W = 6;

    typedef logic [MDU_CNT_W-1:0] mdu_cnt_t;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

    // Register 0 is hardwired to zero, so a write to it never produces a hazard.
    function automatic logic reg_hit(input logic       we,
                                     input logic [4:0] wr,
                                     input logic [4:0] src);
        return we && (wr != 5'd0) && (wr == src);
    endfunction

    function automatic fwd_sel_e fwd_select(input logic [4:0] src,
                                            input logic       rw_m,
                                            input logic [4:0] wr_m,
                                            input logic       rw_w,
                                            input logic [4:0] wr_w);
        if (reg_hit(rw_m, wr_m, src))
            return FWD_MEM;
        else if (reg_hit(rw_w, wr_w, src))
            return FWD_WB;
        else
            return FWD_NONE;
    endfunction

endpackage

// File: rtl/mdu_occupancy.sv
// Tracks how long the multiply/divide unit stays occupied after an issue;
// a new issue always reloads the counter, even mid-operation.
module mdu_occupancy
    import pipeline_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic mdu_start_e,
    input  logic mdu_is_div_e,
    output logic mdu_busy
);

    localparam mdu_cnt_t MULT_LOAD = mdu_cnt_t'(MULT_CYCLES - 1);
    localparam mdu_cnt_t DIV_LOAD  = mdu_cnt_t'(DIV_CYCLES - 1);

    mdu_state_e r_state;
    mdu_cnt_t   r_count;
    mdu_cnt_t   w_load;

    assign w_load   = mdu_is_div_e ? DIV_LOAD : MULT_LOAD;
    assign mdu_busy = (r_state == MDU_BUSY);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MDU_IDLE;
            r_count <= '0;
        end else if (mdu_start_e) begin
            r_state <= MDU_BUSY;
            r_count <= w_load;
        end else if (r_state == MDU_BUSY) begin
            if (r_count == '0)
                r_state <= MDU_IDLE;
            else
                r_count <= r_count - mdu_cnt_t'(1);
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard unit: operand forwarding, load/branch/MDU stalls, control
// flushes and a saturating count of stalled cycles.
module hazard_controller
    import pipeline_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs_d,
    input  logic [4:0]  rt_d,
    input  logic [4:0]  rs_e,
    input  logic [4:0]  rt_e,
    input  logic [4:0]  write_reg_e,
    input  logic [4:0]  write_reg_m,
    input  logic [4:0]  write_reg_w,
    input  logic        reg_write_e,
    input  logic        reg_write_m,
    input  logic        reg_write_w,
    input  logic        mem_to_reg_e,
    input  logic        mem_to_reg_m,
    input  logic        branch_d,
    input  logic        pc_src_d,
    input  logic        jump_d,
    input  logic        hilo_read_d,
    input  logic        mdu_start_e,
    input  logic        mdu_is_div_e,
    output logic        stall_f,
    output logic        stall_d,
    output logic        flush_d,
    output logic        flush_e,
    output logic        forward_a_d,
    output logic        forward_b_d,
    output logic [1:0]  forward_a_e,
    output logic [1:0]  forward_b_e,
    output logic        mdu_busy,
    output logic [31:0] stall_count
);

    logic        w_lw_stall;
    logic        w_br_stall;
    logic        w_mdu_stall;
    logic        w_stall;
    logic        w_mdu_busy;
    logic [31:0] r_stall_count;

    mdu_occupancy #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_mdu_occupancy (
        .clk          (clk),
        .rst          (rst),
        .mdu_start_e  (mdu_start_e),
        .mdu_is_div_e (mdu_is_div_e),
        .mdu_busy     (w_mdu_busy)
    );

    assign forward_a_e = fwd_select(rs_e, reg_write_m, write_reg_m, reg_write_w, write_reg_w);
    assign forward_b_e = fwd_select(rt_e, reg_write_m, write_reg_m, reg_write_w, write_reg_w);
    assign forward_a_d = reg_hit(reg_write_m, write_reg_m, rs_d);
    assign forward_b_d = reg_hit(reg_write_m, write_reg_m, rt_d);

    assign w_lw_stall  = mem_to_reg_e && ((rt_e == rs_d) || (rt_e == rt_d));
    // A branch resolved in decode needs its operands final: an ALU result still
    // in execute, or load data not yet back from memory, forces a wait.
    assign w_br_stall  = branch_d &&
                         (reg_hit(reg_write_e, write_reg_e, rs_d) ||
                          reg_hit(reg_write_e, write_reg_e, rt_d) ||
                          reg_hit(mem_to_reg_m, write_reg_m, rs_d) ||
                          reg_hit(mem_to_reg_m, write_reg_m, rt_d));
    assign w_mdu_stall = hilo_read_d && (w_mdu_busy || mdu_start_e);
    assign w_stall     = w_lw_stall || w_br_stall || w_mdu_stall;

    assign stall_f  = w_stall;
    assign stall_d  = w_stall;
    assign flush_e  = w_stall;
    // Left unmasked by stall; the decode register qualifies its clear itself.
    assign flush_d  = pc_src_d || jump_d;
    assign mdu_busy = w_mdu_busy;

    always_ff @(posedge clk) begin
        if (rst)
            r_stall_count <= '0;
        else if (w_stall && (r_stall_count != '1))
            r_stall_count <= r_stall_count + 32'd1;
    end

    assign stall_count = r_stall_count;

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 Parameter MULT_CYCLES, default 4: MDU multiply occupancy in cycles (range 1..63).
REQ-002 Parameter DIV_CYCLES, default 32: MDU divide occupancy in cycles (range 1..63).
REQ-003 clk  in  1: single clock; all state updates on rising edge.
REQ-004 rst  in  1: synchronous, active-high reset.
REQ-005 rs_d, rt_d  in  5 each: decode-stage source registers.
REQ-006 rs_e, rt_e  in  5 each: execute-stage source registers.
REQ-007 write_reg_e, write_reg_m, write_reg_w  in  5 each: destination register per stage.
REQ-008 reg_write_e, reg_write_m, reg_write_w  in  1 each: destination write enable per stage.
REQ-009 mem_to_reg_e, mem_to_reg_m  in  1 each: stage holds a load.
REQ-010 branch_d  in  1: decode holds a branch compared in decode.
REQ-011 pc_src_d  in  1: decode branch taken; jump_d  in  1: decode holds a jump.
REQ-012 hilo_read_d  in  1: decode holds MFHI/MFLO.
REQ-013 mdu_start_e, mdu_is_div_e  in  1 each: execute issues MULT/DIV; 1 = divide.
REQ-014 stall_f, stall_d  out  1 each: hold fetch PC / decode register.
REQ-015 flush_d, flush_e  out  1 each: clear decode / execute register.
REQ-016 forward_a_d, forward_b_d  out  1 each: decode comparator operand from memory stage.
REQ-017 forward_a_e, forward_b_e  out  2 each: execute ALU operand select.
REQ-018 mdu_busy  out  1: MDU occupied; stall_count  out  32: saturating stall-cycle counter.

Function
REQ-019 Execute forwarding per operand: 2'b10 if reg_write_m, write_reg_m!=0, write_reg_m==rs_e (rt_e for B); else 2'b01 if same on W stage; else 2'b00; M wins over W.
REQ-020 forward_a_d = reg_write_m & write_reg_m!=0 & write_reg_m==rs_d; forward_b_d same with rt_d.
REQ-021 lw_stall = mem_to_reg_e & (rt_e==rs_d | rt_e==rt_d).
REQ-022 br_stall = branch_d & ((reg_write_e & write_reg_e matches rs_d or rt_d) | (mem_to_reg_m & write_reg_m matches rs_d or rt_d)); register 0 never matches.
REQ-023 mdu_stall = hilo_read_d & (mdu_busy | mdu_start_e).
REQ-024 stall = lw_stall | br_stall | mdu_stall; stall_f = stall_d = flush_e = stall; all combinational, same cycle.
REQ-025 flush_d = pc_src_d | jump_d, unmasked by stall; decode register gates its own clear with ~stall_d.
REQ-026 FSM states IDLE, BUSY; mdu_busy = (state==BUSY).
REQ-027 IDLE & mdu_start_e: count <= (is_div ? DIV_CYCLES : MULT_CYCLES)-1, go BUSY.
REQ-028 BUSY & ~mdu_start_e: count==0 -> IDLE; else count decrements.
REQ-029 BUSY & mdu_start_e: counter reloads per new op, stays BUSY (restart supersedes).
REQ-030 Occupancy: start at edge N makes mdu_busy high for exactly the op's cycle count starting cycle N+1.
REQ-031 stall_count increments by 1 at each edge where stall=1; holds at 32'hFFFF_FFFF.

Reset
REQ-032 rst at edge: state IDLE, count 0, stall_count 0; mdu_start_e ignored on that edge.
REQ-033 Reset mid-BUSY aborts the occupancy; mdu_busy low the cycle after the edge.
REQ-034 Combinational outputs track inputs during reset; no reset gating on them.

Structure
REQ-035 Shared package pipeline_pkg holds fwd_sel_e (FWD_NONE=00, FWD_WB=01, FWD_MEM=10), mdu_state_e, and the 6-bit count width constant.
REQ-036 One sub-module mdu_occupancy holding FSM and counter; forwarding/stall logic stays in the top.

Verification
REQ-037 rs_e=5, reg_write_m=1, write_reg_m=5, reg_write_w=1, write_reg_w=5 -> forward_a_e=10; write_reg_m=0 and rs_e=0 -> 00.
REQ-038 mem_to_reg_e=1, rt_e=8, rs_d=8 -> stall_f=stall_d=flush_e=1 same cycle; stall_count +1 per cycle held.
REQ-039 branch_d=1, rs_d=3, reg_write_e=1, write_reg_e=3 -> stall=1; also pc_src_d=1 -> flush_d=1.
REQ-040 DIV start, MFHI in decode next cycle -> stall 32 cycles, released the cycle mdu_busy falls; MULT -> 4 cycles.
REQ-041 MULT start while BUSY with count 20 -> reload, busy 4 more cycles; rst mid-BUSY -> mdu_busy 0 next cycle, stall_count 0.
REQ-042 Force stall_count to 32'hFFFF_FFFE, hold stall 3 cycles -> saturates at 32'hFFFF_FFFF.
